// File: rtl/ro_puf_challenge_sequencer_if.sv
// Host-side request/response bundle for the RO-PUF challenge sequencer.
// slave = sequencer side, master = host/register side.
interface ro_puf_challenge_sequencer_if #(
  parameter int NUM_BITS = 32
);
  logic                start;
  logic                abort;
  logic [7:0]          seed;
  logic                busy;
  logic [NUM_BITS-1:0] resp_word;
  logic                resp_valid;
  logic                resp_ready;

  modport slave  (input  start, abort, seed, resp_ready,
                  output busy, resp_word, resp_valid);
  modport master (output start, abort, seed, resp_ready,
                  input  busy, resp_word, resp_valid);
endinterface

// File: rtl/ro_puf_challenge_sequencer.sv
// Sequences LFSR-chosen RO pairs through reset/measure/sample on the counter group
// and collects one NUM_BITS response word per start (first bit lands in the MSB).
module ro_puf_challenge_sequencer #(
  parameter int NUM_BITS    = 32,
  parameter int RST_CYCLES  = 4,
  parameter int MEAS_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cg_response,
  output logic       cg_reset,
  output logic [3:0] cha0,
  output logic [3:0] cha1,
  ro_puf_challenge_sequencer_if.slave host
);
  localparam int TMAX = (RST_CYCLES > MEAS_CYCLES) ? RST_CYCLES : MEAS_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int BW   = (NUM_BITS > 2) ? $clog2(NUM_BITS) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_RST    = 3'd2;
  localparam logic [2:0] S_MEAS   = 3'd3;
  localparam logic [2:0] S_SAMPLE = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]          state;
  logic [7:0]          lfsr;
  logic [TW-1:0]       timer;
  logic [BW-1:0]       bit_cnt;
  logic [NUM_BITS-1:0] resp_word;
  logic [1:0]          sync_q;
  logic                resp_sync;
  logic [7:0]          seed_eff;
  logic [7:0]          lfsr_adv;

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  // Returns {cha1, cha0}; an RO is never raced against itself.
  function automatic logic [7:0] challenge(input logic [7:0] l);
    logic [3:0] hi;
    hi = (l[7:4] == l[3:0]) ? (l[3:0] ^ 4'h1) : l[7:4];
    return {hi, l[3:0]};
  endfunction

  assign seed_eff  = (host.seed == 8'h00) ? 8'hA5 : host.seed;
  assign lfsr_adv  = lfsr_step(lfsr);
  assign resp_sync = sync_q[1];

  // cg_response comes from the free-running RO domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= 2'b00;
    else       sync_q <= {sync_q[0], cg_response};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      lfsr      <= 8'hA5;
      timer     <= '0;
      bit_cnt   <= '0;
      resp_word <= '0;
      cha0      <= 4'h0;
      cha1      <= 4'h0;
    end else begin
      case (state)
        S_IDLE: if (host.start && !host.abort) state <= S_LOAD;
        S_LOAD: begin
          if (host.abort) state <= S_IDLE;
          else begin
            lfsr         <= seed_eff;
            bit_cnt      <= '0;
            resp_word    <= '0;
            timer        <= '0;
            {cha1, cha0} <= challenge(seed_eff);
            state        <= S_RST;
          end
        end
        S_RST: begin
          if (host.abort) state <= S_IDLE;
          else if (timer == TW'(RST_CYCLES - 1)) begin
            timer <= '0;
            state <= S_MEAS;
          end else timer <= timer + TW'(1);
        end
        S_MEAS: begin
          if (host.abort) state <= S_IDLE;
          else if (timer == TW'(MEAS_CYCLES - 1)) begin
            timer <= '0;
            state <= S_SAMPLE;
          end else timer <= timer + TW'(1);
        end
        S_SAMPLE: begin
          if (host.abort) state <= S_IDLE;
          else begin
            resp_word <= {resp_word[NUM_BITS-2:0], resp_sync};
            if (bit_cnt == BW'(NUM_BITS - 1)) state <= S_DONE;
            else begin
              // Next pair is taken from the advanced LFSR as RST is entered.
              bit_cnt      <= bit_cnt + BW'(1);
              lfsr         <= lfsr_adv;
              {cha1, cha0} <= challenge(lfsr_adv);
              timer        <= '0;
              state        <= S_RST;
            end
          end
        end
        S_DONE:  if (host.resp_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign cg_reset        = (state != S_MEAS);
  assign host.busy       = (state != S_IDLE);
  assign host.resp_valid = (state == S_DONE);
  assign host.resp_word  = resp_word;
endmodule
